// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Round-robin arbiter granting one of three register-file write
//            requesters per cycle, with registered grant/write outputs.
// Option   : RF_WB_ARB_STATS_EN enables the saturating contention counter.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int DW   = 8,
  parameter int AW   = 3,
  parameter int NREQ = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    ack,
  output logic          regwrite,
  output logic [AW-1:0] srin,
  output logic [DW-1:0] rin,
  output logic          drop,
  output logic [7:0]    conflict_cnt
);

  localparam logic [1:0] c_last_rst = 2'd2;

  logic [2:0]    r_ack;
  logic          r_regwrite;
  logic          r_drop;
  logic [AW-1:0] r_srin;
  logic [DW-1:0] r_rin;
  logic [1:0]    r_last;

  logic [2:0]    w_elig;
  logic          w_grant_vld;
  logic [1:0]    w_grant_idx;
  logic [AW-1:0] w_grant_addr;
  logic [DW-1:0] w_grant_data;
  logic          w_multi_elig;

  // Position k of the search order that begins just after the last grant.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + 3'd1 + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // A requester acked this cycle is already served and must not win again.
  assign w_elig       = req & ~r_ack;
  assign w_multi_elig = (w_elig[0] & w_elig[1]) | (w_elig[0] & w_elig[2]) |
                        (w_elig[1] & w_elig[2]);

  always_comb begin
    logic [1:0] v_idx;
    w_grant_vld = 1'b0;
    w_grant_idx = 2'd0;
    v_idx       = 2'd0;
    // Walk from the lowest priority slot upward so the first slot wins.
    for (int k = 2; k >= 0; k--) begin
      v_idx = rr_idx(r_last, k[1:0]);
      if (w_elig[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_grant_addr = addr0;
    w_grant_data = data0;
    case (w_grant_idx)
      2'd1: begin
        w_grant_addr = addr1;
        w_grant_data = data1;
      end
      2'd2: begin
        w_grant_addr = addr2;
        w_grant_data = data2;
      end
      default: begin
        w_grant_addr = addr0;
        w_grant_data = data0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 3'b000;
      r_regwrite <= 1'b0;
      r_drop     <= 1'b0;
      r_srin     <= '0;
      r_rin      <= '0;
      r_last     <= c_last_rst;
    end else if (w_grant_vld) begin
      r_ack      <= 3'b001 << w_grant_idx;
      r_srin     <= w_grant_addr;
      r_rin      <= w_grant_data;
      // Writes to r0 are acknowledged but never reach the register file.
      r_regwrite <= (w_grant_addr != '0);
      r_drop     <= (w_grant_addr == '0);
      r_last     <= w_grant_idx;
    end else begin
      r_ack      <= 3'b000;
      r_regwrite <= 1'b0;
      r_drop     <= 1'b0;
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [7:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= 8'd0;
    end else if (w_multi_elig && (r_conflict_cnt != 8'hFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_multi_elig;
  assign conflict_cnt   = 8'd0;
`endif

  assign ack      = r_ack;
  assign regwrite = r_regwrite;
  assign drop     = r_drop;
  assign srin     = r_srin;
  assign rin      = r_rin;

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DW, 8, write-data width; AW, 3, register-address width; NREQ, 3, requester count (fixed at 3).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  3  per-requester write request; bit i belongs to requester i.
REQ-005 addr0/addr1/addr2  input  3 each  target register of requester i.
REQ-006 data0/data1/data2  input  8 each  write data of requester i.
REQ-007 ack  output  3  one-cycle grant pulse to requester i.
REQ-008 regwrite  output  1  register-file write enable.
REQ-009 srin  output  3  register-file write address.
REQ-010 rin  output  8  register-file write data.
REQ-011 drop  output  1  pulse: granted write targeted r0 and was discarded.
REQ-012 conflict_cnt  output  8  contention statistic (see Configuration).

Function
REQ-013 Requester protocol: hold req[i], addr_i and data_i stable until the cycle ack[i]=1; req[i] may be deasserted or kept high (new request) in the ack cycle.
REQ-014 Each cycle at most one requester SHALL be granted; eligible = req[i]=1 and ack[i]=0 in that cycle.
REQ-015 Arbitration SHALL be round-robin: search order starts at (last+1) mod 3, where last is the index of the most recent grant.
REQ-016 Grant decided in cycle N SHALL be registered; in cycle N+1 ack[g]=1 and srin=addr_g, rin=data_g as sampled at the end of cycle N.
REQ-017 In cycle N+1 regwrite SHALL be 1 if the captured address is nonzero; the register file commits at the edge ending cycle N+1 (2-edge latency from request sampling).
REQ-018 Captured address 0: ack[g] SHALL still pulse, regwrite=0, drop=1; last SHALL still advance.
REQ-019 With no eligible requester: ack=0, regwrite=0, drop=0 next cycle; srin/rin hold their previous values; last unchanged.
REQ-020 Throughput: distinct requesters SHALL be serviced in consecutive cycles; a single continuously requesting requester SHALL be serviced at most every second cycle.
REQ-021 Starvation bound: a held request SHALL be acked within 3 cycles of first being sampled eligible.
REQ-022 ack, regwrite and drop SHALL never be asserted without a corresponding registered grant; ack is one-hot or zero.

Reset
REQ-023 While rst=1 at a rising edge: ack=0, regwrite=0, drop=0, srin=0, rin=0, last=2, conflict_cnt=0.
REQ-024 rst SHALL take priority over any grant; a grant decided in the reset cycle is discarded with no ack; held requests SHALL re-arbitrate from the first cycle after rst deasserts, requester 0 first.

Configuration
REQ-025 Macro RF_WB_ARB_STATS_EN: when defined, conflict_cnt SHALL increment by 1 each non-reset cycle with two or more eligible requesters, saturating at 255.
REQ-026 When RF_WB_ARB_STATS_EN is undefined, conflict_cnt SHALL be constant 0 with no counter logic; all other behaviour identical.

Verification
REQ-027 Post-reset req=3'b111, addr0=1/data0=8'h11, addr1=2/data1=8'h22, addr2=3/data2=8'h33, each dropping req on its ack -> ack=001,010,100 on three consecutive cycles; srin/rin = 1/11, 2/22, 3/33; regwrite=1 each.
REQ-028 req0 held high continuously with addr0=5, data0=8'hA5, others idle -> ack[0] and regwrite on alternate cycles, srin=5, rin=8'hA5.
REQ-029 req1 with addr1=0, data1=8'hFF -> ack[1]=1, drop=1, regwrite=0 for one cycle; next grant order starts at requester 2.
REQ-030 req=3'b011 held, rst asserted in the cycle a grant is decided -> no ack during reset; after release ack[0] first, outputs 0 during reset.
REQ-031 With RF_WB_ARB_STATS_EN, all three requesting continuously for 300 cycles -> conflict_cnt saturates at 255; without the macro it stays 0.
